mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/cpu_pkg.sv | 19 +
 rtl/arb_burst_ctr.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory-port arbiter slice.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] HALT_OPCODE = 16'hF000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DATA   = 2'd2,
        ST_HALTED = 2'd3
    } arb_state_e;

    function automatic logic is_halt_opcode(input logic [15:0] instr);
        return (instr == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/arb_burst_ctr.sv
// Saturating count of data grants made while a fetch is waiting.
module arb_burst_ctr #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (inc_i && (cnt_q != CW'(MAX_BURST))) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CW'(MAX_BURST));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data
// accesses, one access in flight, with fetch starvation relief and halt.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              halted,
    output logic              protocol_err
);

    arb_state_e        state_q, state_d;
    logic              halt_q, halt_d;
    logic              ret_halt_q, ret_halt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              perr_q, perr_d;
    logic              halted_q, halted_d;

    logic dm_req_s;
    logic if_req_s;
    logic at_max_s;
    logic grant_fetch_s;
    logic grant_data_s;
    logic port_free_s;

    assign dm_req_s    = dm_re | dm_we;
    assign if_req_s    = if_req & ~halt_q;
    assign port_free_s = (state_q == ST_IDLE) || (state_q == ST_HALTED);

    // Grant selection: data first unless the fetch side has been starved
    always_comb begin
        grant_fetch_s = 1'b0;
        grant_data_s  = 1'b0;
        if (port_free_s) begin
            if (dm_req_s && !(if_req_s && at_max_s)) begin
                grant_data_s = 1'b1;
            end else if (if_req_s) begin
                grant_fetch_s = 1'b1;
            end else begin
                grant_data_s = 1'b0;
            end
        end else begin
            grant_fetch_s = 1'b0;
        end
    end

    arb_burst_ctr #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (grant_fetch_s | ~if_req),
        .inc_i   (grant_data_s & if_req),
        .at_max_o(at_max_s)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q | halt;
        ret_halt_d  = ret_halt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        perr_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                // Remember where to go back to once this access finishes
                ret_halt_d = (state_q == ST_HALTED);
                if (grant_data_s) begin
                    state_d     = ST_DATA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    perr_d      = dm_re & dm_we;
                end else if (grant_fetch_s) begin
                    state_d     = ST_FETCH;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = {DATA_W{1'b0}};
                end else if (halt_q) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (mem_ready) begin
                    state_d  = ret_halt_q ? ST_HALTED : ST_IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == ST_FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_done_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            halt_q      <= 1'b0;
            ret_halt_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            perr_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            ret_halt_q  <= ret_halt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            perr_q      <= perr_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign if_done      = if_done_q;
    assign dm_done      = dm_done_q;
    assign protocol_err = perr_q;
    assign halted       = halted_q;
    assign stall        = (if_req & ~halt_q & ~if_done_q) | (dm_req_s & ~dm_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_re = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          halt = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall;
    logic          halted;
    logic          protocol_err;

    int n_checks = 0;
    int n_err    = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .halt(halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .halted(halted), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Memory: 256 words, ready after wait_n stalled cycles
    logic [DW-1:0] mem_arr [256];
    int            wait_n = 0;
    int            en_cnt = 0;

    assign mem_ready = mem_en && (en_cnt >= wait_n);
    assign mem_rdata = mem_arr[mem_addr[7:0]];

    always @(posedge clk) begin
        if (rst || !mem_en || mem_ready) en_cnt <= 0;
        else en_cnt <= en_cnt + 1;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'(i * 3);
        forever begin
            @(posedge clk);
            if (!rst && mem_en && mem_ready && mem_we) mem_arr[mem_addr[7:0]] = mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending transaction, a starvation tally, a halt flag
    logic          m_busy, m_fetch, m_we, m_parked, m_ret_parked, m_hlt;
    logic          m_if_done, m_dm_done, m_perr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
    int            m_burst;

    task automatic model_reset();
        m_busy = 0; m_fetch = 0; m_we = 0; m_parked = 0; m_ret_parked = 0; m_hlt = 0;
        m_if_done = 0; m_dm_done = 0; m_perr = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0; m_burst = 0;
    endtask

    task automatic model_step();
        logic fg, dg, dreq, freq;
        fg = 0; dg = 0;
        m_if_done = 0; m_dm_done = 0; m_perr = 0;
        if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                if (m_fetch) begin
                    m_if_done = 1; m_if_rdata = mem_arr[m_addr[7:0]];
                end else begin
                    m_dm_done = 1;
                    if (!m_we) m_dm_rdata = mem_arr[m_addr[7:0]];
                end
                m_parked = m_ret_parked;
            end
        end else begin
            dreq = dm_re || dm_we;
            freq = if_req && !m_hlt;
            if (freq && (!dreq || m_burst == MB)) fg = 1;
            else if (dreq) dg = 1;
            if (fg || dg) begin
                m_ret_parked = m_parked;
                m_parked = 0;
                m_busy = 1;
                m_fetch = fg;
                m_we = dg && dm_we;
                m_addr = fg ? if_addr : dm_addr;
                m_wdata = dm_wdata;
                m_perr = dg && dm_re && dm_we;
            end else begin
                m_parked = m_hlt;
            end
        end
        if (fg || !if_req) m_burst = 0;
        else if (dg && m_burst < MB) m_burst++;
        if (halt) m_hlt = 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("mem_en", mem_en, m_busy);
                if (m_busy) begin
                    chk("mem_addr", mem_addr, m_addr);
                    chk("mem_we", mem_we, m_we);
                    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                end
                chk("if_done", if_done, m_if_done);
                chk("dm_done", dm_done, m_dm_done);
                chk("protocol_err", protocol_err, m_perr);
                chk("halted", halted, m_parked);
                chk("if_rdata", if_rdata, m_if_rdata);
                chk("dm_rdata", dm_rdata, m_dm_rdata);
                chk("stall", stall,
                    (if_req && !m_hlt && !m_if_done) || ((dm_re || dm_we) && !m_dm_done));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios with hand-computed expectations
    initial begin
        logic [5:0] seq;
        int         n;
        logic       prev_en;
        logic       seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_rdata", if_rdata, 16'h0000);
        chk("rst_dm_rdata", dm_rdata, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_dm_done", dm_done, 1'b0);
        rst = 1'b0;

        // Zero-wait fetch
        mem_arr[8'h10] = 16'h1234;
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        chk("s1_mem_en", mem_en, 1'b1);
        chk("s1_mem_addr", mem_addr, 16'h0010);
        tick();
        chk("s1_if_done", if_done, 1'b1);
        chk("s1_if_rdata", if_rdata, 16'h1234);
        if_req = 1'b0;
        tick();
        chk("s1_done_pulse", if_done, 1'b0);

        // Simultaneous fetch and store: store first
        if_req = 1'b1; if_addr = 16'h0012;
        dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h0007;
        tick();
        chk("s2_mem_we", mem_we, 1'b1);
        chk("s2_mem_addr", mem_addr, 16'h0040);
        chk("s2_mem_wdata", mem_wdata, 16'h0007);
        tick();
        chk("s2_dm_done", dm_done, 1'b1);
        dm_we = 1'b0;
        tick();
        chk("s2_fetch_en", mem_en, 1'b1);
        chk("s2_fetch_addr", mem_addr, 16'h0012);
        chk("s2_fetch_we", mem_we, 1'b0);
        tick();
        chk("s2_if_done", if_done, 1'b1);
        if_req = 1'b0;
        tick();

        // Read and write together: treated as write, error pulse
        dm_re = 1'b1; dm_we = 1'b1; dm_addr = 16'h0048; dm_wdata = 16'h0033;
        tick();
        chk("pe_pulse", protocol_err, 1'b1);
        chk("pe_mem_we", mem_we, 1'b1);
        tick();
        chk("pe_cleared", protocol_err, 1'b0);
        chk("pe_done", dm_done, 1'b1);
        dm_re = 1'b0; dm_we = 1'b0;
        tick();

        // Continuous data reads against a waiting fetch
        dm_re = 1'b1; dm_addr = 16'h0030;
        if_req = 1'b1; if_addr = 16'h0050;
        n = 0; seq = '0; prev_en = 1'b0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (if_done) if_req = 1'b0;
            if (mem_en && !prev_en) begin
                seq[n] = (mem_addr == 16'h0050);
                n++;
            end
            prev_en = mem_en;
        end
        chk("s3_grants", n, 6);
        chk("s3_sequence", seq, 6'b010000);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            seen = dm_done;
        end
        chk("s3_last_done", seen, 1'b1);
        dm_re = 1'b0; if_req = 1'b0;
        tick();

        // Read with three wait cycles
        wait_n = 3;
        mem_arr[8'h20] = 16'hBEEF;
        dm_re = 1'b1; dm_addr = 16'h0020;
        #1;
        chk("s4_stall_req", stall, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("s4_hold_en", mem_en, 1'b1);
            chk("s4_hold_addr", mem_addr, 16'h0020);
            chk("s4_stall", stall, 1'b1);
            chk("s4_no_done", dm_done, 1'b0);
        end
        tick();
        chk("s4_done", dm_done, 1'b1);
        chk("s4_rdata", dm_rdata, 16'hBEEF);
        dm_re = 1'b0;
        tick();

        // Halt during a fetch, then a store
        wait_n = 1;
        mem_arr[8'h60] = 16'hF000;
        if_req = 1'b1; if_addr = 16'h0060;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        chk("s5_if_done", if_done, 1'b1);
        chk("s5_if_rdata", if_rdata, 16'hF000);
        dm_we = 1'b1; dm_addr = 16'h0044; dm_wdata = 16'h0055;
        tick();
        chk("s5_store_en", mem_en, 1'b1);
        chk("s5_store_addr", mem_addr, 16'h0044);
        tick();
        tick();
        chk("s5_dm_done", dm_done, 1'b1);
        dm_we = 1'b0;
        tick();
        chk("s5_halted", halted, 1'b1);
        repeat (2) begin
            tick();
            chk("s5_fetch_ignored", mem_en, 1'b0);
        end
        wait_n = 0;
        dm_re = 1'b1; dm_addr = 16'h0044;
        tick();
        chk("s5_h_grant", mem_en, 1'b1);
        chk("s5_h_busy", halted, 1'b0);
        tick();
        chk("s5_h_rdata", dm_rdata, 16'h0055);
        chk("s5_h_back", halted, 1'b1);
        dm_re = 1'b0;
        tick();

        // Reset while a data access is waiting
        if_req = 1'b0;
        wait_n = 10;
        dm_we = 1'b1; dm_addr = 16'h0070; dm_wdata = 16'h0009;
        tick();
        chk("s6_busy", mem_en, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_en", mem_en, 1'b0);
        chk("s6_async_halted", halted, 1'b0);
        chk("s6_no_done", dm_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0; dm_we = 1'b0; wait_n = 0;
        mem_arr[8'h80] = 16'hAAAA;
        if_req = 1'b1; if_addr = 16'h0080;
        tick();
        chk("s6_first_grant", mem_en, 1'b1);
        chk("s6_fetch_addr", mem_addr, 16'h0080);
        chk("s6_no_dm_done", dm_done, 1'b0);
        tick();
        chk("s6_if_rdata", if_rdata, 16'hAAAA);
        if_req = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
